// File: rtl/instmem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instmem_pkg;

    // Loader control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // RV32 OP-IMM major opcode; ADDI x0,x0,0 is the canonical NOP
    localparam logic [6:0]  OPC_OP_IMM       = 7'b0010011;
    localparam logic [31:0] NOP_WORD_DEFAULT = {12'd0, 5'd0, 3'd0, 5'd0, OPC_OP_IMM};

    // Even-parity bit: makes the total number of ones (data + bit) even
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/instmem_bank_ram.sv
// Flat word array holding every program bank; synchronous write, registered read.
// Latency: read data valid one cycle after i_re; write lands on the same edge.
// Backpressure: none, accepts a read and a write every cycle.
module instmem_bank_ram #(
    parameter int DW  = 32,
    parameter int RAW = 8
) (
    input  logic           clk,
    input  logic           i_we,
    input  logic [RAW-1:0] i_waddr,
    input  logic [DW-1:0]  i_wdata,
    input  logic           i_re,
    input  logic [RAW-1:0] i_raddr,
    output logic [DW-1:0]  o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<RAW)-1];
    logic [DW-1:0] r_rdata;

    // Array write and read-register update; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instmem_loadable.sv
// Banked instruction memory with a streaming loader; optional per-word parity (INSTMEM_PARITY_EN).
// Latency: fetch_en in IDLE at cycle N gives inst/inst_valid at N+1; loader words written on acceptance.
// Backpressure: ld_ready high only while loading; fetches are ignored while busy (core must stall).
module instmem_loadable
    import instmem_pkg::*;
#(
    parameter int          AW       = 6,
    parameter int          NBANK    = 4,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    clrn,
    input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] bank_sel,
    input  logic [31:0]                             a,
    input  logic                                    fetch_en,
    output logic [31:0]                             inst,
    output logic                                    inst_valid,
    output logic                                    fault,
    input  logic                                    ld_start,
    input  logic                                    ld_valid,
    input  logic [31:0]                             ld_data,
    input  logic                                    ld_last,
    output logic                                    ld_ready,
    output logic                                    busy
);

    localparam int BW  = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int RAW = AW + $clog2(NBANK);
`ifdef INSTMEM_PARITY_EN
    localparam int DW  = 33;
`else
    localparam int DW  = 32;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_ld_ptr;
    logic [BW-1:0]   r_ld_bank;
    logic            r_inst_valid;
    logic            r_fault;
    logic            r_use_nop;

    logic            w_ld_acc;
    logic            w_ld_end;
    logic            w_fetch;
    logic            w_addr_bad;
    logic            w_par_err;
    logic [DW-1:0]   w_wdata;
    logic [DW-1:0]   w_rdata;
    logic [RAW-1:0]  w_waddr;
    logic [RAW-1:0]  w_raddr;

    assign ld_ready   = (r_state == LOAD);
    assign busy       = (r_state == LOAD);
    assign w_ld_acc   = ld_valid && ld_ready;
    // Filling the last word ends the load even without ld_last, so the pointer never wraps
    assign w_ld_end   = ld_last || (r_ld_ptr == {AW{1'b1}});
    assign w_fetch    = fetch_en && (r_state == IDLE);
    assign w_addr_bad = (a[1:0] != 2'b00) || (a[31:AW+2] != '0);

    // Bank index sits above the word index; truncation drops the dummy bank bit when NBANK==1
    assign w_raddr = RAW'({bank_sel, a[AW+1:2]});
    assign w_waddr = RAW'({r_ld_bank, r_ld_ptr});

    // Loader state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Loader next-state; ld_start only honoured from IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (ld_start) w_state_nxt = LOAD;
            LOAD:    if (w_ld_acc && w_ld_end) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Load pointer and target bank, latched at ld_start so bank_sel may move during the load
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ld_ptr  <= '0;
            r_ld_bank <= '0;
        end else if ((r_state == IDLE) && ld_start) begin
            r_ld_ptr  <= '0;
            r_ld_bank <= bank_sel;
        end else if (w_ld_acc) begin
            r_ld_ptr  <= r_ld_ptr + 1'b1;
        end
    end

    // Fetch result flags; r_use_nop selects NOP_WORD over array data and holds between fetches
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_use_nop    <= 1'b1;
        end else begin
            r_inst_valid <= w_fetch;
            if (w_fetch) begin
                r_fault   <= w_addr_bad;
                r_use_nop <= w_addr_bad;
            end
        end
    end

`ifdef INSTMEM_PARITY_EN
    assign w_wdata   = {even_parity(ld_data), ld_data};
    assign w_par_err = !r_use_nop && (even_parity(w_rdata[31:0]) != w_rdata[32]);
`else
    assign w_wdata   = ld_data;
    assign w_par_err = 1'b0;
`endif

    instmem_bank_ram #(
        .DW  (DW),
        .RAW (RAW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ld_acc),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_fetch && !w_addr_bad),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign inst       = (r_use_nop || w_par_err) ? NOP_WORD : w_rdata[31:0];
    assign fault      = r_fault || w_par_err;
    assign inst_valid = r_inst_valid;

endmodule

// File: tb/tb_instmem_loadable.sv
// Scoreboard bench for instmem_loadable: fetches push expectations, a monitor pops on inst_valid.
// Latency: expects each fetch result exactly one cycle after issue.
// Backpressure: loader words are only offered while the block is expected to be loading.
module tb_instmem_loadable;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        clrn;
    logic [1:0]  bank_sel;
    logic [31:0] a;
    logic        fetch_en;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fault;
    logic        ld_start;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        busy;

    typedef struct {
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    instmem_loadable #(.AW(6), .NBANK(4), .NOP_WORD(32'h00000013)) u_dut (
        .clk        (clk),
        .clrn       (clrn),
        .bank_sel   (bank_sel),
        .a          (a),
        .fetch_en   (fetch_en),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fault      (fault),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Issue one fetch at the current negedge and record its expected result
    task automatic fetch(input logic [1:0] bank, input logic [31:0] addr,
                         input logic [31:0] exp_inst, input logic exp_fault);
        exp_t e;
        e.inst  = exp_inst;
        e.fault = exp_fault;
        bank_sel = bank;
        a        = addr;
        fetch_en = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        fetch_en = 1'b0;
    endtask

    // Stream n words base+i into a bank; fetches, a stray word and a stray ld_start are
    // offered during LOAD/DONE and must all be ignored
    task automatic load_words(input logic [1:0] bank, input int n,
                              input logic [31:0] base, input bit use_last);
        bank_sel = bank;
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        bank_sel = bank ^ 2'b10;
        check("ld_busy_start", {31'd0, busy}, 32'd1);
        check("ld_ready_start", {31'd0, ld_ready}, 32'd1);
        fetch_en = 1'b1;
        a        = 32'h0;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = base + 32'(i);
            ld_last  = use_last && (i == n - 1);
            @(negedge clk);
        end
        check("ld_ready_done", {31'd0, ld_ready}, 32'd0);
        check("ld_busy_done", {31'd0, busy}, 32'd0);
        ld_last  = 1'b0;
        ld_data  = 32'hDEADBEEF;
        ld_start = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_start = 1'b0;
        fetch_en = 1'b0;
        check("ld_start_in_done_ignored", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: every inst_valid must match the oldest outstanding fetch, one cycle after issue
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (inst_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: inst=%08h with no outstanding fetch", inst);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("fetch_inst", inst, e.inst);
                    check("fetch_fault", {31'd0, fault}, {31'd0, e.fault});
                end
            end else if (sb_q.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_valid: inst_valid=0, expected %08h", sb_q[0].inst);
                void'(sb_q.pop_front());
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        clrn     = 1'b0;
        bank_sel = 2'd0;
        a        = 32'h0;
        fetch_en = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 32'h0;
        ld_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inst", inst, NOP);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        // Bank 0 program, then basic fetches
        load_words(2'd0, 8, 32'h100, 1'b1);
        fetch(2'd0, 32'h0,  32'h100, 1'b0);
        fetch(2'd0, 32'h1C, 32'h107, 1'b0);

        // Bank 2 short load; bank_sel moved to 0 during it must not redirect writes
        load_words(2'd2, 4, 32'hA0, 1'b1);
        fetch(2'd2, 32'h8, 32'hA2, 1'b0);
        fetch(2'd0, 32'h8, 32'h102, 1'b0);

        // Misaligned and out-of-range fetches, then recovery
        fetch(2'd0, 32'h2,   NOP, 1'b1);
        fetch(2'd0, 32'h100, NOP, 1'b1);
        @(negedge clk);
        check("hold_inst_after_fault", inst, NOP);
        check("hold_fault", {31'd0, fault}, 32'd1);
        check("idle_inst_valid", {31'd0, inst_valid}, 32'd0);
        fetch(2'd0, 32'h4, 32'h101, 1'b0);
        @(negedge clk);
        check("hold_inst_valid_fetch", inst, 32'h101);
        check("hold_fault_clear", {31'd0, fault}, 32'd0);
        fetch(2'd0, 32'h8000_0000, NOP, 1'b1);

        // Full bank without ld_last: 64 words fill it, the 65th offered word must not wrap
        load_words(2'd1, 64, 32'h200, 1'b0);
        fetch(2'd1, 32'h0,  32'h200, 1'b0);
        fetch(2'd1, 32'hFC, 32'h23F, 1'b0);

        // Reset in the middle of a bank 3 reload
        load_words(2'd3, 8, 32'h300, 1'b1);
        bank_sel = 2'd3;
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h400 + 32'(i);
            @(negedge clk);
        end
        ld_data = 32'h403;
        clrn    = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("midrst_inst", inst, NOP);
        @(negedge clk);
        check("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
        clrn     = 1'b1;
        ld_valid = 1'b0;
        @(negedge clk);
        fetch(2'd3, 32'h0,  32'h400, 1'b0);
        fetch(2'd3, 32'h4,  32'h401, 1'b0);
        fetch(2'd3, 32'h8,  32'h402, 1'b0);
        fetch(2'd3, 32'hC,  32'h303, 1'b0);
        fetch(2'd3, 32'h10, 32'h304, 1'b0);

`ifdef INSTMEM_PARITY_EN
        // Corrupt one data bit of bank 0 word 5 behind the parity bit's back
        u_dut.u_ram.r_mem[5] = u_dut.u_ram.r_mem[5] ^ 33'h1;
        fetch(2'd0, 32'h14, NOP, 1'b1);
        fetch(2'd0, 32'h18, 32'h106, 1'b0);
`endif

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instmem_loadable.md
INSTMEM_LOADABLE -- requirements
Module: instmem_loadable

Interface
REQ-001 SHALL have parameter AW, default 6, word-address width (depth = 2**AW words).
REQ-002 SHALL have parameter NBANK, default 4, number of program banks (must be a power of two, >= 1).
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013, word returned for invalid fetches.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port clrn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port bank_sel, input, log2(NBANK) (min 1), program bank for fetch and load.
REQ-007 SHALL have port a, input, 32, byte fetch address.
REQ-008 SHALL have port fetch_en, input, 1, fetch request.
REQ-009 SHALL have port inst, output, 32, fetched instruction.
REQ-010 SHALL have port inst_valid, output, 1, inst holds a fetch result.
REQ-011 SHALL have port fault, output, 1, last fetch was misaligned or out of range.
REQ-012 SHALL have port ld_start, input, 1, pulse: begin loading bank_sel from word 0.
REQ-013 SHALL have port ld_valid, input, 1, loader data valid.
REQ-014 SHALL have port ld_data, input, 32, loader word.
REQ-015 SHALL have port ld_last, input, 1, marks final loader word.
REQ-016 SHALL have port ld_ready, output, 1, block accepts loader word.
REQ-017 SHALL have port busy, output, 1, load in progress; core must stall.

Function
REQ-018 SHALL store NBANK x 2**AW words; fetch word index = a[AW+1:2] within bank bank_sel.
REQ-019 SHALL use FSM states IDLE, LOAD, DONE; IDLE->LOAD on ld_start, LOAD->DONE on accepted ld_last or write to final word, DONE->IDLE after one cycle.
REQ-020 SHALL assert ld_ready and busy only in LOAD; a word is accepted when ld_valid && ld_ready, written at the load pointer, pointer incremented.
REQ-021 SHALL latch bank_sel on ld_start; bank_sel changes during LOAD do not affect the load target.
REQ-022 SHALL, when the load pointer wraps past 2**AW-1, terminate the load as if ld_last (no wrap-around overwrite).
REQ-023 SHALL ignore ld_start while in LOAD or DONE.
REQ-024 SHALL register fetch output: fetch_en in IDLE at cycle N yields inst and inst_valid=1 at cycle N+1; otherwise inst_valid=0 and inst holds.
REQ-025 SHALL ignore fetch_en in LOAD and DONE (inst_valid=0).
REQ-026 SHALL return NOP_WORD with fault=1 when a[1:0]!=0 or a[31:AW+2]!=0; fault=0 on any valid fetch; fault holds when no fetch.
REQ-027 SHALL give read-old-data semantics: no same-cycle load/fetch overlap exists by REQ-025.

Reset
REQ-028 SHALL on clrn low: FSM=IDLE, load pointer=0, inst=NOP_WORD, inst_valid=0, fault=0, ld_ready=0, busy=0.
REQ-029 SHALL not reset memory contents; reset mid-LOAD aborts the load, leaving already-written words intact.

Configuration
REQ-030 SHALL, with INSTMEM_PARITY_EN defined, store an even-parity bit per word at load time and on fetch of a word with a parity mismatch return NOP_WORD with fault=1.
REQ-031 SHALL, without INSTMEM_PARITY_EN, store no parity bits and perform no parity check.

Structure
REQ-032 SHALL place the FSM state enum, NOP_WORD default and the opcode constants in shared package instmem_pkg.
REQ-033 SHALL use one sub-module, instmem_bank_ram (synchronous-write, registered-read array), instantiated once with NBANK*2**AW depth.

Verification
REQ-034 Reset then fetch a=0 bank 0 -> inst_valid=1 next cycle, contents as loaded, fault=0.
REQ-035 ld_start bank 2, load 4 words 0xA0..0xA3 with ld_last on 4th -> busy 4+ cycles, fetch bank 2 a=0x8 returns 0xA2.
REQ-036 Fetch a=0x2 and a=0x100 (AW=6) -> inst=0x00000013, fault=1; following fetch a=0x4 -> fault=0.
REQ-037 Load 65 words without ld_last (AW=6) -> ld_ready drops after word 64, word 0 unchanged at 1st loaded value.
REQ-038 clrn low after 3 of 8 load words -> FSM IDLE, busy=0, words 0-2 retained, word 3 unchanged.
REQ-039 With INSTMEM_PARITY_EN, force-flip a stored bit of word 5 -> fetch a=0x14 yields 0x00000013, fault=1.
